nv_nvdla_cdma_wg_fifo_drain: RTL

Read-side consumer of the CDMA Winograd command FIFO (128x5). It pops 5-bit group descriptors over the FIFO's rd_req/rd_ready valid/ready interface and expands each one into a burst of indexed beats on a downstream valid/ready port. A one-entry lookahead buffer lets consecutive descriptors stream with no idle cycles. It also keeps status counters for the CDMA debug registers.

---
 rtl/nv_nvdla_cdma_wg_pkg.sv | 28 ++
 rtl/nv_nvdla_cdma_wg_sat_cnt.sv | 34 +++
 rtl/nv_nvdla_cdma_wg_fifo_drain.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_cdma_wg_pkg.sv
// Definitions shared by the Winograd command FIFO writer and reader.
// Covers the descriptor layout and the reader FSM states.
package nv_nvdla_cdma_wg_pkg;

  localparam int WG_LEN_W         = 4;
  localparam int WG_DESC_LAST_BIT = WG_LEN_W;
  localparam int WG_DESC_LEN_MSB  = WG_LEN_W - 1;
  localparam int WG_DESC_W        = WG_LEN_W + 1;

  // A descriptor holds the last-group flag above the beats-minus-one field
  typedef struct packed {
    logic                last_grp;
    logic [WG_LEN_W-1:0] len;
  } wg_desc_t;

  typedef enum logic {
    WG_IDLE = 1'b0,
    WG_RUN  = 1'b1
  } wg_state_e;

  function automatic wg_desc_t wg_desc_pack(input logic last_grp, input logic [WG_LEN_W-1:0] len);
    wg_desc_t d;
    d.last_grp = last_grp;
    d.len      = len;
    return d;
  endfunction

endpackage

// File: rtl/nv_nvdla_cdma_wg_sat_cnt.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module nv_nvdla_cdma_wg_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/nv_nvdla_cdma_wg_fifo_drain.sv
// Pops Winograd group descriptors from the command FIFO and expands each into a
// burst of indexed beats; a one-entry lookahead slot keeps consecutive groups gapless.
module nv_nvdla_cdma_wg_fifo_drain
  import nv_nvdla_cdma_wg_pkg::*;
#(
  parameter int LEN_W  = WG_LEN_W,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              in_req,
  output logic              in_ready,
  input  logic [LEN_W:0]    in_data,
  output logic              out_req,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  out_idx,
  output logic              out_last_beat,
  output logic              out_last_grp,
  output logic              grp_done,
  output logic              busy,
  output logic [STAT_W-1:0] stat_grp_cnt,
  output logic [STAT_W-1:0] stat_beat_cnt,
  input  logic              stat_clr
);

  wg_state_e        state_q, state_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic             cur_last_q, cur_last_d;
  logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
  logic             nxt_vld_q, nxt_vld_d;
  logic [LEN_W-1:0] nxt_len_q, nxt_len_d;
  logic             nxt_last_q, nxt_last_d;
  logic             grp_done_q, grp_done_d;

  logic             cur_vld;
  logic             in_fire;
  logic             out_fire;
  logic             at_end;
  logic             cur_end;
  logic             desc_last;
  logic [LEN_W-1:0] desc_len;

  assign desc_last = in_data[LEN_W];
  assign desc_len  = in_data[LEN_W-1:0];

  assign cur_vld  = (state_q == WG_RUN);
  // in_ready depends on registered state only, so the FIFO sees no comb loop
  assign in_ready = ~nxt_vld_q;
  assign in_fire  = in_req & in_ready;
  assign out_fire = cur_vld & out_ready;
  assign at_end   = (beat_idx_q == cur_len_q);
  assign cur_end  = out_fire & at_end;

  always_comb begin
    state_d    = state_q;
    cur_len_d  = cur_len_q;
    cur_last_d = cur_last_q;
    beat_idx_d = beat_idx_q;
    nxt_vld_d  = nxt_vld_q;
    nxt_len_d  = nxt_len_q;
    nxt_last_d = nxt_last_q;
    grp_done_d = cur_end & cur_last_q;

    unique case (state_q)
      WG_IDLE: begin
        if (in_fire) begin
          cur_len_d  = desc_len;
          cur_last_d = desc_last;
          beat_idx_d = '0;
          state_d    = WG_RUN;
        end
      end
      WG_RUN: begin
        if (cur_end) begin
          beat_idx_d = '0;
          if (nxt_vld_q) begin
            cur_len_d  = nxt_len_q;
            cur_last_d = nxt_last_q;
            nxt_vld_d  = 1'b0;
          end else if (in_fire) begin
            cur_len_d  = desc_len;
            cur_last_d = desc_last;
          end else begin
            state_d = WG_IDLE;
          end
        end else begin
          if (out_fire) begin
            beat_idx_d = beat_idx_q + LEN_W'(1);
          end
          if (in_fire) begin
            nxt_len_d  = desc_len;
            nxt_last_d = desc_last;
            nxt_vld_d  = 1'b1;
          end
        end
      end
      default: state_d = WG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= WG_IDLE;
      cur_len_q  <= '0;
      cur_last_q <= 1'b0;
      beat_idx_q <= '0;
      nxt_vld_q  <= 1'b0;
      nxt_len_q  <= '0;
      nxt_last_q <= 1'b0;
      grp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_len_q  <= cur_len_d;
      cur_last_q <= cur_last_d;
      beat_idx_q <= beat_idx_d;
      nxt_vld_q  <= nxt_vld_d;
      nxt_len_q  <= nxt_len_d;
      nxt_last_q <= nxt_last_d;
      grp_done_q <= grp_done_d;
    end
  end

  assign out_req       = cur_vld;
  assign out_idx       = beat_idx_q;
  assign out_last_beat = cur_vld & at_end;
  assign out_last_grp  = cur_vld & cur_last_q;
  assign grp_done      = grp_done_q;
  assign busy          = cur_vld | nxt_vld_q;

  nv_nvdla_cdma_wg_sat_cnt #(.W(STAT_W)) u_grp_cnt (
    .clk     (clk),
    .rst_n_i (reset_),
    .clr_i   (stat_clr),
    .inc_i   (in_fire),
    .cnt_o   (stat_grp_cnt)
  );

  nv_nvdla_cdma_wg_sat_cnt #(.W(STAT_W)) u_beat_cnt (
    .clk     (clk),
    .rst_n_i (reset_),
    .clr_i   (stat_clr),
    .inc_i   (out_fire),
    .cnt_o   (stat_beat_cnt)
  );

endmodule
